// File: rtl/denorm_seq.sv
// Sequential right-shift denormalizer: restores fixed-point alignment of a
// normalized mantissa one bit per clock, tracking guard/sticky and optionally rounding.
module denorm_seq #(
   parameter bit ROUND    = 1'b1,
   parameter int MAXSHIFT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [15:0] i_mant,
   input  logic [4:0]  i_shift,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_data,
   output logic        o_guard,
   output logic        o_sticky,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [4:0] MAX_CNT = 5'(MAXSHIFT);

   state_t      state;
   logic [15:0] sreg;
   logic [4:0]  cnt;
   logic        guard;
   logic        sticky;

   logic [4:0]  shift_clamped;
   logic [15:0] sreg_next;
   logic        guard_next;
   logic        sticky_next;
   logic [15:0] round_inc;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      shift_clamped = (i_shift > MAX_CNT) ? MAX_CNT : i_shift;
      sreg_next     = {1'b0, sreg[15:1]};
      guard_next    = sreg[0];
      sticky_next   = sticky | guard;
      round_inc     = {15'd0, ROUND & guard_next};
   end

   // Handshake flags decode directly from the state register; no input feeds them.
   assign o_ready = (state == IDLE);
   assign o_busy  = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sreg     <= '0;
         cnt      <= '0;
         guard    <= 1'b0;
         sticky   <= 1'b0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_guard  <= 1'b0;
         o_sticky <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  sreg   <= i_mant;
                  cnt    <= shift_clamped;
                  guard  <= 1'b0;
                  sticky <= 1'b0;
                  if (shift_clamped == 5'd0) begin
                     // Zero shift: pass the mantissa through unrounded.
                     o_data   <= i_mant;
                     o_guard  <= 1'b0;
                     o_sticky <= 1'b0;
                     o_valid  <= 1'b1;
                     state    <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end

            SHIFT: begin
               sreg   <= sreg_next;
               guard  <= guard_next;
               sticky <= sticky_next;
               cnt    <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  // Bit 15 of sreg_next is zero, so the increment cannot overflow.
                  o_data   <= sreg_next + round_inc;
                  o_guard  <= guard_next;
                  o_sticky <= sticky_next;
                  o_valid  <= 1'b1;
                  state    <= DONE;
               end
            end

            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state   <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_denorm_seq.sv
// Self-checking bench for denorm_seq: directed steps with a scoreboard queue of
// expected results, plus a truncating (ROUND=0) instance sharing the same stimulus.
module tb_denorm_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b0;
   logic [15:0] i_mant = '0;
   logic [4:0]  i_shift = '0;

   logic        o_ready, o_valid, o_guard, o_sticky, o_busy;
   logic [15:0] o_data;
   logic        t_ready, t_valid, t_guard, t_sticky, t_busy;
   logic [15:0] t_data;

   always #5 clk = ~clk;

   denorm_seq #(.ROUND(1'b1), .MAXSHIFT(16)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_mant(i_mant), .i_shift(i_shift), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_guard(o_guard), .o_sticky(o_sticky), .o_busy(o_busy)
   );

   denorm_seq #(.ROUND(1'b0), .MAXSHIFT(16)) dut_t (
      .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(t_ready),
      .i_mant(i_mant), .i_shift(i_shift), .o_valid(t_valid), .i_ready(i_ready),
      .o_data(t_data), .o_guard(t_guard), .o_sticky(t_sticky), .o_busy(t_busy)
   );

   typedef struct {
      logic [15:0] data;
      logic        guard;
      logic        sticky;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   passes = 0;
   int   total  = 0;
   int   fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: shift the mantissa as a 32-bit word; the low half holds the shifted-out bits.
   function automatic exp_t model(input logic [15:0] m, input logic [4:0] s);
      exp_t        e;
      int          c;
      logic [31:0] w;
      c        = (s > 5'd16) ? 16 : int'(s);
      w        = {m, 16'h0000} >> c;
      e.guard  = w[15];
      e.sticky = |w[14:0];
      e.data   = w[31:16] + {15'd0, e.guard};
      e.lat    = c + 1;
      return e;
   endfunction

   task automatic push_exp(input logic [15:0] d, input logic g, input logic s, input int lat);
      exp_t e;
      e.data = d; e.guard = g; e.sticky = s; e.lat = lat;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic drive_req(input logic [15:0] m, input logic [4:0] s);
      check("ready_before_req", o_ready, 1);
      i_mant  = m;
      i_shift = s;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      i_mant  = $urandom;
      i_shift = 5'($urandom);
   endtask

   task automatic collect(input string tag);
      int   n;
      exp_t e;
      n = 1;
      while (o_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, o_valid, 1);
      if (sb.size() == 0) begin
         check({tag, "_sb_nonempty"}, sb.size(), 1);
      end else begin
         e = sb.pop_front();
         check({tag, "_lat"}, n, e.lat);
         check({tag, "_data"}, o_data, e.data);
         check({tag, "_guard"}, o_guard, e.guard);
         check({tag, "_sticky"}, o_sticky, e.sticky);
         check({tag, "_busy"}, o_busy, 1);
      end
   endtask

   task automatic take(input string tag);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check({tag, "_cleared"}, o_valid, 0);
      check({tag, "_idle"}, o_ready, 1);
   endtask

   exp_t        e;
   exp_t        bp;
   int          acc[3];
   logic [15:0] tp_m[3];
   logic [4:0]  tp_s[3];
   int          cyc, idx, got;
   bit          seen;

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", o_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_guard", o_guard, 0);
      check("rst_sticky", o_sticky, 0);
      check("rst_busy", o_busy, 0);
      check("rst_ready", o_ready, 1);
      reset = 1'b0;
      @(negedge clk);

      // Plain shift, no guard
      push_exp(16'h0800, 1'b0, 1'b0, 5);
      drive_req(16'h8000, 5'd4);
      collect("basic");
      take("basic");

      // Round half-up, guard only
      push_exp(16'h0002, 1'b1, 1'b0, 2);
      drive_req(16'h0003, 5'd1);
      collect("rnd_g");
      take("rnd_g");

      // Guard and sticky; truncating instance yields 0x0001
      push_exp(16'h0002, 1'b1, 1'b1, 3);
      drive_req(16'h0007, 5'd2);
      collect("rnd_gs");
      check("trunc_valid", t_valid, 1);
      check("trunc_data", t_data, 16'h0001);
      take("rnd_gs");

      // Zero shift
      push_exp(16'hABCD, 1'b0, 1'b0, 1);
      drive_req(16'hABCD, 5'd0);
      collect("zero");
      take("zero");

      // Clamp 20 -> 16
      push_exp(16'h0001, 1'b1, 1'b1, 17);
      drive_req(16'hFFFF, 5'd20);
      collect("clamp");
      check("clamp_trunc_data", t_data, 16'h0000);
      take("clamp");

      // Backpressure with an ignored request in DONE
      bp = model(16'hF0F5, 5'd3);
      sb.push_back(bp);
      drive_req(16'hF0F5, 5'd3);
      collect("bp");
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin
            i_mant  = 16'h5555;
            i_shift = 5'd0;
            i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         check("bp_hold_valid", o_valid, 1);
         check("bp_hold_data", o_data, bp.data);
         check("bp_hold_ready", o_ready, 0);
      end
      i_valid = 1'b0;
      take("bp");
      sb.push_back(model(16'h00FF, 5'd8));
      drive_req(16'h00FF, 5'd8);
      collect("bp_next");
      take("bp_next");

      // Asynchronous reset mid-shift
      drive_req(16'h8000, 5'd12);
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", o_valid, 0);
      check("arst_data", o_data, 0);
      check("arst_guard", o_guard, 0);
      check("arst_sticky", o_sticky, 0);
      check("arst_busy", o_busy, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("arst_ready", o_ready, 1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (o_valid === 1'b1) seen = 1'b1;
      end
      check("arst_no_result", seen, 0);

      // Back-to-back throughput with i_ready held high
      tp_m[0] = 16'h1234; tp_s[0] = 5'd3;
      tp_m[1] = 16'hBEEF; tp_s[1] = 5'd0;
      tp_m[2] = 16'h8001; tp_s[2] = 5'd19;
      i_ready = 1'b1;
      cyc = 0; idx = 0; got = 0;
      while (got < 3 && cyc < 200) begin
         if (o_valid === 1'b1) begin
            e = sb.pop_front();
            check("tp_data", o_data, e.data);
            check("tp_guard", o_guard, e.guard);
            check("tp_sticky", o_sticky, e.sticky);
            got++;
         end
         if (o_ready === 1'b1 && idx < 3) begin
            i_mant  = tp_m[idx];
            i_shift = tp_s[idx];
            i_valid = 1'b1;
            sb.push_back(model(tp_m[idx], tp_s[idx]));
            acc[idx] = cyc;
            idx++;
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      check("tp_count", got, 3);
      check("tp_gap01", acc[1] - acc[0], 5);
      check("tp_gap12", acc[2] - acc[1], 2);
      @(negedge clk);

      // Random requests against the reference
      for (int r = 0; r < 4; r++) begin
         logic [15:0] m;
         logic [4:0]  s;
         m = 16'($urandom);
         s = 5'($urandom_range(0, 31));
         sb.push_back(model(m, s));
         drive_req(m, s);
         collect("rand");
         take("rand");
      end

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/denorm_seq.md
Name: denorm_seq

Overview:
- Sequential right-shift denormalizer: the inverse path to the leading-zero-count normalizer.
- Takes a normalized 16-bit mantissa and a 5-bit shift count, as produced by the normalizer's leading-zero count. Shifts the mantissa right one bit per clock back to fixed-point alignment.
- Tracks guard and sticky bits and optionally rounds half-up.
- Sits after the reciprocal/normalize datapath in the ray-stepping pipeline; uses a valid/ready handshake on both sides.

Parameters:
ROUND, 1, 1 = round half-up using the guard bit at completion; 0 = truncate.
MAXSHIFT, 16, shift counts above this value are clamped to it (fixed at 16 for the 16-bit datapath).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
i_valid  input  1  request valid.
o_ready  output  1  block can accept a request; high only in IDLE.
i_mant  input  16  mantissa to denormalize.
i_shift  input  5  right-shift count, 0..31; values above 16 are clamped to 16.
o_valid  output  1  result valid; held until taken.
i_ready  input  1  downstream accepts the result.
o_data  output  16  shifted (and optionally rounded) result.
o_guard  output  1  last bit shifted out.
o_sticky  output  1  OR of all bits shifted out before the guard bit.
o_busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - o_valid = 0, o_data = 0, o_guard = 0, o_sticky = 0, o_busy = 0.
  - Internal shift register and counter cleared.
  - Any operation in flight is abandoned with no output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready = 1.
  - Accept on a rising edge with i_valid = 1. The accept edge loads:
    - sreg = i_mant
    - cnt = min(i_shift, 16)
    - guard = 0, sticky = 0
  - Next state: SHIFT if the clamped count > 0, else DONE.
- SHIFT, each cycle:
  - sticky |= guard
  - guard = sreg[0]
  - sreg = sreg >> 1 (zero fill)
  - cnt -= 1
  - On the edge where cnt goes 1 -> 0, also register the outputs and enter DONE.
- Output registration (on DONE entry):
  - o_data = sreg_shifted + (ROUND & guard_new)
  - o_guard = guard_new
  - o_sticky = sticky_new
  - o_valid = 1
  - Count = 0 path: o_data = i_mant, guard = 0, sticky = 0, no rounding.
- Rounding overflow: cannot occur. After at least one shift, bit 15 is 0, so adding 1 fits in 16 bits. No saturation logic is required.
- Latency: o_valid rises exactly (clamped count + 1) cycles after the accept edge.
  - Count 0: 1 cycle.
  - Count 16: 17 cycles.
- DONE:
  - o_valid, o_data, o_guard and o_sticky are held stable while i_ready = 0.
  - On an edge with i_ready = 1: o_valid clears and state returns to IDLE.
  - o_ready is not high in DONE, so no back-to-back accept on the same edge. Minimum issue interval = clamped count + 2 cycles.
- i_valid outside IDLE is ignored. i_mant and i_shift are sampled only on the accept edge and may change freely afterwards.
- Clamped shift of 16: the result is 0 before rounding; guard = original bit 15; sticky = OR of original bits 14..0.
- o_busy = (state != IDLE).
- No combinational path from i_valid/i_ready to any output other than through state.

Test Plan:
- Basic, truncate path exercised with ROUND=1: i_mant=0x8000, i_shift=4 -> o_data=0x0800, guard=0, sticky=0; o_valid rises 5 cycles after accept.
- Round half-up: 0x0003 shift 1 -> guard=1, sticky=0, o_data=0x0002.
  - 0x0007 shift 2 -> guard=1, sticky=1, o_data=0x0002.
  - Same 0x0007 shift 2 with ROUND=0 -> o_data=0x0001.
- Zero shift and clamp:
  - 0xABCD shift 0 -> o_data=0xABCD one cycle after accept.
  - 0xFFFF shift 20 -> clamped to 16: guard=1, sticky=1, o_data=0x0001, latency 17.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_data stable, o_ready=0. A new i_valid pulse during this time is ignored. Release i_ready -> IDLE next cycle, and the next request is accepted.
- Reset mid-shift: accept 0x8000 shift 12, assert reset at cycle 5 -> all outputs 0 immediately (asynchronous). After release, state is IDLE with o_ready=1, and the abandoned result never appears.
- Back-to-back throughput: three requests with i_ready tied high -> each accepted exactly (clamped count + 2) cycles apart, with results in order and correct.
